// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation/state encodings and op-class helpers shared by the
// multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  function automatic logic isSignedOp(input muldiv_op_e op);
    case (op)
      OP_MULT, OP_DIV, OP_MADD: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic isDivOp(input muldiv_op_e op);
    case (op)
      OP_DIV, OP_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration, either a shift-add
// multiply step (right shift) or a restoring divide step (left shift).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  part_in,
  input  logic [WIDTH-1:0]  operand,
  input  logic              div_mode,
  output logic [2*WIDTH:0]  part_out
);

  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH:0] sh_s;
  logic [WIDTH+1:0] trial_s;

  // Multiply: {acc, multiplier} with acc one bit wider for the add carry.
  // Divide:   {remainder, quotient/dividend}; borrow out means restore.
  always_comb begin
    if (part_in[0]) begin
      sum_s = part_in[2*WIDTH:WIDTH] + {1'b0, operand};
    end else begin
      sum_s = part_in[2*WIDTH:WIDTH];
    end
    sh_s    = {part_in[2*WIDTH-1:0], 1'b0};
    trial_s = {1'b0, sh_s[2*WIDTH:WIDTH]} - {2'b00, operand};
    if (div_mode) begin
      if (!trial_s[WIDTH+1]) begin
        part_out = {trial_s[WIDTH:0], sh_s[WIDTH-1:1], 1'b1};
      end else begin
        part_out = sh_s;
      end
    end else begin
      part_out = {1'b0, sum_s, part_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with architectural HI/LO registers.
// Define MULDIV_MADD_EN to enable MADD/MADDU (accumulate product into {hi,lo}).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;
`ifdef MULDIV_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  muldiv_state_e    state_r;
  logic [CW-1:0]    cnt_r;
  logic [PW-1:0]    part_r;
  logic [WIDTH-1:0] opnd_r;
  logic             div_r;
  logic             madd_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dz_r;

  muldiv_op_e         op_s;
  logic               long_op_s;
  logic               mt_op_s;
  logic               accept_s;
  logic               sgn_s;
  logic               div_op_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [PW-1:0]      step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] res_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  assign op_s     = muldiv_op_e'(op);
  assign accept_s = start && (state_r == IDLE);

  // Decode the requested op and form operand magnitudes.
  always_comb begin
    long_op_s = 1'b0;
    mt_op_s   = 1'b0;
    case (op_s)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op_s = 1'b1;
      OP_MADD, OP_MADDU:                  long_op_s = MADD_EN;
      OP_MTHI, OP_MTLO:                   mt_op_s   = 1'b1;
      default: begin
        long_op_s = 1'b0;
        mt_op_s   = 1'b0;
      end
    endcase
    sgn_s    = isSignedOp(op_s);
    div_op_s = isDivOp(op_s);
    if (sgn_s && a[WIDTH-1]) begin
      abs_a_s = -a;
    end else begin
      abs_a_s = a;
    end
    if (sgn_s && b[WIDTH-1]) begin
      abs_b_s = -b;
    end else begin
      abs_b_s = b;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .part_in  (part_r),
    .operand  (opnd_r),
    .div_mode (div_r),
    .part_out (step_s)
  );

  // Sign fixup of the magnitude result; divide-by-zero forces an all-ones quotient.
  always_comb begin
    if (neg_q_r) begin
      prod_s = -part_r[2*WIDTH-1:0];
    end else begin
      prod_s = part_r[2*WIDTH-1:0];
    end
    if (madd_r) begin
      res_s = {hi, lo} + prod_s;
    end else begin
      res_s = prod_s;
    end
    if (dz_r) begin
      quo_s = {WIDTH{1'b1}};
    end else if (neg_q_r) begin
      quo_s = -part_r[WIDTH-1:0];
    end else begin
      quo_s = part_r[WIDTH-1:0];
    end
    if (neg_r_r) begin
      rem_s = -part_r[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = part_r[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      part_r  <= {PW{1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      div_r   <= 1'b0;
      madd_r  <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && long_op_s) begin
            part_r  <= {{(WIDTH+1){1'b0}}, div_op_s ? abs_a_s : abs_b_s};
            opnd_r  <= div_op_s ? abs_b_s : abs_a_s;
            div_r   <= div_op_s;
            madd_r  <= (op_s == OP_MADD) || (op_s == OP_MADDU);
            neg_q_r <= sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r <= sgn_s && a[WIDTH-1];
            dz_r    <= div_op_s && (b == {WIDTH{1'b0}});
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            divZero <= 1'b0;
            state_r <= CALC;
          end else if (accept_s && mt_op_s) begin
            if (op_s == OP_MTHI) begin
              hi <= a;
            end else begin
              lo <= a;
            end
            divZero <= 1'b0;
          end
        end
        CALC: begin
          part_r <= step_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (div_r) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            hi <= res_s[2*WIDTH-1:WIDTH];
            lo <= res_s[WIDTH-1:0];
          end
          divZero <= dz_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed scoreboard bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = 32'd0;
  logic [W-1:0] b = 32'd0;
  logic         busy, done, divZero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] hi_m = 32'd0;
  logic [W-1:0] lo_m = 32'd0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divZero(divZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
    return (o <= 3'd3) || ((o >= 3'd6) && MADD_ON);
  endfunction

  // Reference model: architectural HI/LO computed with plain wide arithmetic.
  task automatic apply_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic dz);
    int          sx, sy;
    logic [63:0] p, acc;
    sx = x;
    sy = y;
    dz = 1'b0;
    case (o)
      3'd0: {hi_m, lo_m} = 64'(longint'(sx) * longint'(sy));
      3'd1: {hi_m, lo_m} = {32'd0, x} * {32'd0, y};
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          lo_m = 32'hFFFFFFFF; hi_m = x; dz = 1'b1;
        end else if (o == 3'd2 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          lo_m = 32'h80000000; hi_m = 32'd0;
        end else if (o == 3'd2) begin
          lo_m = sx / sy; hi_m = sx % sy;
        end else begin
          lo_m = x / y; hi_m = x % y;
        end
      end
      3'd4: hi_m = x;
      3'd5: lo_m = x;
      3'd6: begin
        p = 64'(longint'(sx) * longint'(sy));
        acc = {hi_m, lo_m} + p;
        {hi_m, lo_m} = acc;
      end
      default: begin
        p = {32'd0, x} * {32'd0, y};
        acc = {hi_m, lo_m} + p;
        {hi_m, lo_m} = acc;
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int   n;
    logic dz;
    exp_t e;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_wait_timeout", 32'(busy), 32'd0);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    if (is_long(o)) begin
      apply_model(o, x, y, dz);
      e.hi = hi_m; e.lo = lo_m; e.dz = dz; e.cyc = cyc + W + 1;
      sb.push_back(e);
      chk("busy_on_accept", 32'(busy), 32'd1);
      chk("dz_clear_on_accept", 32'(divZero), 32'd0);
    end else begin
      if (o == 3'd4 || o == 3'd5) begin
        apply_model(o, x, y, dz);
        chk("mt_dz_clear", 32'(divZero), 32'd0);
      end
      chk("short_op_no_busy", 32'(busy), 32'd0);
      chk("short_op_hi", hi, hi_m);
      chk("short_op_lo", lo, lo_m);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_hi", hi, e.hi);
        chk("res_lo", lo, e.lo);
        chk("res_divZero", 32'(divZero), 32'(e.dz));
        chk("done_latency", 32'(cyc), 32'(e.cyc));
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_divZero", 32'(divZero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full-width unsigned multiply; busy must hold through every CALC cycle.
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_during_calc", 32'(busy), 32'd1);
    end

    issue(3'd0, 32'hFFFFFFF9, 32'd3);
    issue(3'd0, 32'h80000000, 32'h80000000);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd3, 32'h00001234, 32'd0);
    issue(3'd1, 32'd2, 32'd3);

    // A start while busy must be ignored.
    issue(3'd1, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    issue(3'd1, 32'd5, 32'd5);

    // Asynchronous reset in the middle of CALC discards everything.
    issue(3'd1, 32'h00011111, 32'h00022222);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    sb.delete();
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'd3, 32'hFFFFFFFE);
    repeat (W + 4) @(negedge clk);

    for (int i = 0; i < 50; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (W + 4) @(negedge clk);
    chk("final_hi", hi, hi_m);
    chk("final_lo", lo, lo_m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
